// File: rtl/iter_int_mul_param.sv
// Iterative shift-add multiplier, A_W x B_W -> A_W+B_W, signed or unsigned per request.
// Latency k+1 cycles (k = max(1, bit-length of |a|)); request is held off and the result holds until consumed.
module iter_int_mul_param #(
  parameter int A_W = 8,
  parameter int B_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [A_W-1:0]       req_a,
  input  logic [B_W-1:0]       req_b,
  input  logic                 req_signed,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [A_W+B_W-1:0]   resp_prod,
  output logic                 busy
);
  localparam int P_W = A_W + B_W;
  localparam int C_W = $clog2(A_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [A_W-1:0]   mag_a_q, mag_a_d;
  logic [P_W-1:0]   mag_b_q, mag_b_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [P_W-1:0]   prod_q, prod_d;
  logic [C_W-1:0]   cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [A_W-1:0]   abs_a;
  logic [B_W-1:0]   abs_b;

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    p_d     = p_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    // Most-negative inputs negate to themselves, which read unsigned is the right magnitude.
    abs_a   = (req_signed && req_a[A_W-1]) ? -req_a : req_a;
    abs_b   = (req_signed && req_b[B_W-1]) ? -req_b : req_b;
    case (state_q)
      IDLE: begin
        if (req_val) begin
          mag_a_d = abs_a;
          mag_b_d = P_W'(abs_b);
          neg_d   = req_signed & (req_a[A_W-1] ^ req_b[B_W-1]);
          p_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (mag_a_q[0]) p_d = p_q + mag_b_q;
        mag_a_d = mag_a_q >> 1;
        mag_b_d = mag_b_q << 1;
        cnt_d   = cnt_q + C_W'(1);
        if (mag_a_d == '0 || cnt_d == C_W'(A_W)) begin
          prod_d  = neg_q ? -p_d : p_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      p_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      p_q     <= p_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign req_rdy   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign resp_val  = (state_q == DONE);
  assign resp_prod = prod_q;
endmodule

// File: tb/tb_iter_int_mul_param.sv
// Bench for iter_int_mul_param: default 8x32 instance plus a 4x12 instance, scoreboarded against an arithmetic model.
module tb_iter_int_mul_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        r0_val = 0, r0_rdy, r0_s = 0, s0_val, s0_rdy = 1, busy0;
  logic [7:0]  r0_a = 0;
  logic [31:0] r0_b = 0;
  logic [39:0] s0_prod;
  logic        r1_val = 0, r1_rdy, r1_s = 0, s1_val, s1_rdy = 1, busy1;
  logic [3:0]  r1_a = 0;
  logic [11:0] r1_b = 0;
  logic [15:0] s1_prod;

  iter_int_mul_param #(.A_W(8), .B_W(32)) dut0 (
    .clk(clk), .reset(reset), .req_val(r0_val), .req_rdy(r0_rdy), .req_a(r0_a), .req_b(r0_b),
    .req_signed(r0_s), .resp_val(s0_val), .resp_rdy(s0_rdy), .resp_prod(s0_prod), .busy(busy0));
  iter_int_mul_param #(.A_W(4), .B_W(12)) dut1 (
    .clk(clk), .reset(reset), .req_val(r1_val), .req_rdy(r1_rdy), .req_a(r1_a), .req_b(r1_b),
    .req_signed(r1_s), .resp_val(s1_val), .resp_rdy(s1_rdy), .resp_prod(s1_prod), .busy(busy1));

  int n_cmp = 0, n_err = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] eq0[$], eq1[$];
  int          lq0[$], lq1[$];
  longint      aq0[$], aq1[$];
  longint      ret0 = 0;
  logic        pv0 = 0, pv1 = 0;
  logic [39:0] hp0 = 0;
  logic [15:0] hp1 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: sign-extend as the mode dictates, multiply as plain integers, keep the product width.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input int aw, input int bw, input bit s);
    longint sa, sb, p;
    sa = longint'(a & ((64'd1 << aw) - 1));
    sb = longint'(b & ((64'd1 << bw) - 1));
    if (s && a[aw-1]) sa = sa - (longint'(1) << aw);
    if (s && b[bw-1]) sb = sb - (longint'(1) << bw);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (aw + bw)) - 1);
  endfunction

  function automatic int exp_lat(input logic [63:0] a, input int aw, input bit s);
    logic [63:0] m;
    int k;
    m = a & ((64'd1 << aw) - 1);
    if (s && m[aw-1]) m = ((64'd1 << aw) - m) & ((64'd1 << aw) - 1);
    k = 0;
    while (m != 0) begin k++; m = m >> 1; end
    if (k == 0) k = 1;
    return k + 1;
  endfunction

  always @(negedge clk) begin
    if (s0_val && !pv0) begin
      chk("pending0", 64'(lq0.size()), 64'd1);
      if (lq0.size() > 0) chk("latency0", 64'(cyc - aq0.pop_front()), 64'(lq0.pop_front()));
    end
    if (s0_val && pv0) chk("hold0", 64'(s0_prod), 64'(hp0));
    if (s0_val && s0_rdy) begin
      if (eq0.size() > 0) chk("prod0", 64'(s0_prod), eq0.pop_front());
      ret0 = cyc;
    end
    pv0 = s0_val;
    hp0 = s0_prod;
  end

  always @(negedge clk) begin
    if (s1_val && !pv1) begin
      chk("pending1", 64'(lq1.size()), 64'd1);
      if (lq1.size() > 0) chk("latency1", 64'(cyc - aq1.pop_front()), 64'(lq1.pop_front()));
    end
    if (s1_val && pv1) chk("hold1", 64'(s1_prod), 64'(hp1));
    if (s1_val && s1_rdy && eq1.size() > 0) chk("prod1", 64'(s1_prod), eq1.pop_front());
    pv1 = s1_val;
    hp1 = s1_prod;
  end

  task automatic issue(input int inst, input logic [63:0] a, input logic [63:0] b, input bit s,
                       input logic [63:0] exp, output longint acc);
    int n = 0;
    acc = -1;
    do begin @(negedge clk); n++; end while (!(inst == 0 ? r0_rdy : r1_rdy) && n < 400);
    if (n >= 400) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout inst%0d: req_rdy stayed 0, required 1", inst);
      return;
    end
    acc = cyc;
    if (inst == 0) begin
      r0_a = a[7:0]; r0_b = b[31:0]; r0_s = s; r0_val = 1;
      eq0.push_back(exp); lq0.push_back(exp_lat(a, 8, s)); aq0.push_back(acc);
    end else begin
      r1_a = a[3:0]; r1_b = b[11:0]; r1_s = s; r1_val = 1;
      eq1.push_back(exp); lq1.push_back(exp_lat(a, 4, s)); aq1.push_back(acc);
    end
    @(posedge clk); #1;
    // Junk on the operand lines after acceptance must not disturb the operation.
    r0_val = 0; r1_val = 0;
    r0_a = 8'($urandom); r0_b = $urandom; r0_s = 1'($urandom);
    r1_a = 4'($urandom); r1_b = 12'($urandom); r1_s = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((eq0.size() != 0 || eq1.size() != 0) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: pending %0d/%0d responses, required 0", eq0.size(), eq1.size());
    end
  endtask

  logic [63:0] ra, rb;
  bit          rs, done;
  longint      acc;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_val0", 64'(s0_val), 0);   chk("rst_prod0", 64'(s0_prod), 0);
    chk("rst_rdy0", 64'(r0_rdy), 1);   chk("rst_busy0", 64'(busy0), 0);
    chk("rst_val1", 64'(s1_val), 0);   chk("rst_rdy1", 64'(r1_rdy), 1);

    issue(0, 5, 7, 0, 64'h23, acc);
    drain();
    @(negedge clk);
    chk("single_cycle_val", 64'(s0_val), 0);

    issue(0, 'hFF, 'hFFFF_FFFF, 0, 64'hFE_FFFF_FF01, acc);
    issue(0, 3, 4, 0, 64'hC, acc);
    chk("back_to_back_gap", 64'(acc - ret0), 64'd1);
    issue(0, 'hFD, 5, 1, 64'hFF_FFFF_FFF1, acc);
    issue(0, 'h80, 'h8000_0000, 1, 64'h40_0000_0000, acc);
    issue(0, 'h7F, 'hFFFF_FFFF, 1, 64'hFF_FFFF_FF81, acc);
    issue(0, 0, 'hDEAD_BEEF, 0, 64'h0, acc);
    issue(0, 0, 'hDEAD_BEEF, 1, 64'h0, acc);
    drain();

    s0_rdy = 0;
    issue(0, 'h9C, 'h1234_5678, 1, model('h9C, 'h1234_5678, 8, 32, 1), acc);
    for (int n = 0; n < 100 && !s0_val; n++) @(negedge clk);
    chk("bp_val_seen", 64'(s0_val), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req_rdy", 64'(r0_rdy), 0);
      chk("bp_busy", 64'(busy0), 1);
      r0_a = 8'($urandom); r0_b = $urandom; r0_s = 1'($urandom);
    end
    @(posedge clk); #1 s0_rdy = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_retire_rdy", 64'(r0_rdy), 1);

    issue(0, 'hFF, 3, 0, 64'h2FD, acc);
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    eq0.delete(); lq0.delete(); aq0.delete();
    @(negedge clk);
    chk("mid_rst_val", 64'(s0_val), 0);  chk("mid_rst_prod", 64'(s0_prod), 0);
    chk("mid_rst_rdy", 64'(r0_rdy), 1);  chk("mid_rst_busy", 64'(busy0), 0);
    repeat (12) @(negedge clk);
    issue(0, 2, 3, 0, 64'h6, acc);
    drain();

    done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          case ($urandom_range(0, 3))
            0: ra = 0;
            1: ra = 64'($urandom_range(1, 15));
            default: ra = 64'($urandom);
          endcase
          rb = 64'($urandom);
          rs = 1'($urandom);
          issue(0, ra, rb, rs, model(ra, rb, 8, 32, rs), acc);
        end
        drain();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 s0_rdy = ($urandom_range(0, 3) != 0);
        end
        s0_rdy = 1;
      end
    join

    issue(1, 'hF, 'hFFF, 0, 64'hEFF1, acc);
    issue(1, 'h8, 'h800, 1, 64'h4000, acc);
    for (int i = 0; i < 24; i++) begin
      ra = 64'($urandom); rb = 64'($urandom); rs = 1'($urandom);
      issue(1, ra, rb, rs, model(ra, rb, 4, 12, rs), acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iter_int_mul_param.md
Name: iter_int_mul_param

Overview:
- Parametrised, self-contained iterative shift-add integer multiplier: datapath plus control FSM, with val/rdy request and response handshakes.
- Replaces the fixed 8x32 unsigned datapath that needs an external controller.
- Adds configurable operand widths, a per-request signed/unsigned mode, early termination when the remaining multiplier bits are zero, and output backpressure.
- Sits between an issuing pipeline stage and a writeback stage.

Parameters:
- A_W, 8, multiplier (shifted-right operand) width; ≥2.
- B_W, 32, multiplicand (shifted-left operand) width; ≥2.
- P_W is derived, not a parameter: P_W = A_W + B_W, the product width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready; high only in IDLE.
- req_a  in  A_W  multiplier operand.
- req_b  in  B_W  multiplicand operand.
- req_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- resp_val  out  1  product valid.
- resp_rdy  in  1  consumer ready.
- resp_prod  out  P_W  product, full width, no truncation.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset:
  - Synchronous and active-high; the clock is clk and the reset is reset.
  - reset=1 at an edge forces state IDLE, clears all internal registers, and drives resp_prod=0, resp_val=0, busy=0, req_rdy=1 from the next cycle.
  - Reset overrides everything, including mid-CALC and mid-DONE; any in-flight operation is discarded with no response.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - req_rdy=1.
  - On req_val&&req_rdy:
    - Latch magA = |req_a| and magB = |req_b|; the absolute value is taken only if req_signed, otherwise the raw value is used.
    - Magnitudes are held unsigned in A_W/B_W bits. The most-negative value maps to 2^(A_W-1) / 2^(B_W-1), which fits.
    - Latch neg = req_signed & (req_a MSB ^ req_b MSB).
    - Clear P and iteration counter; go to CALC.
  - With no handshake, state and outputs are held.
- CALC, one multiplier bit per cycle:
  - If magA[0], P <= P + magB_shifted (P_W-bit add; cannot overflow).
  - Then magA >>= 1, magB_shifted <<= 1 (zero-extended into P_W bits), counter++.
  - Exit to DONE when the post-shift magA==0 or the counter reaches A_W, whichever comes first.
  - A zero multiplier therefore spends exactly 1 CALC cycle.
- Transition CALC->DONE:
  - resp_prod <= neg ? -P (P_W two's complement) : P.
  - resp_val=1 from the first DONE cycle.
- Latency:
  - Let k = max(1, bit-length of magA).
  - resp_val rises k+1 cycles after the acceptance edge (k CALC cycles, then DONE).
  - Worst case is A_W+1.
- DONE:
  - resp_val=1 and resp_prod held stable until resp_val&&resp_rdy; then go to IDLE.
  - req_rdy=0 throughout DONE, so there is no same-cycle accept-on-retire.
  - The next request is accepted in the IDLE cycle after retirement.
- Mode independence:
  - req_signed applies per request.
  - req_a/req_b/req_signed are ignored outside the IDLE handshake cycle; changes during CALC/DONE have no effect.
- Results:
  - Unsigned results equal req_a*req_b exactly.
  - Signed results equal the sign-correct P_W-bit two's-complement product, which is always representable.

Test Plan:
- Unsigned 5 x 7, resp_rdy=1 -> resp_prod=0x00_0000_0023; resp_val rises 4 cycles after acceptance (k=3); one cycle of resp_val.
- Unsigned 0xFF x 0xFFFF_FFFF -> resp_prod=0xFE_FFFF_FF01; latency 9; a second back-to-back request is accepted one cycle after retirement.
- Signed cases:
  - -3 (0xFD) x 5 -> 0xFF_FFFF_FFF1.
  - -128 (0x80) x 0x8000_0000 -> 0x40_0000_0000.
  - 0x7F x -1 -> 0xFF_FFFF_FF81.
- req_a=0, req_b=0xDEAD_BEEF -> resp_prod=0, resp_val 2 cycles after acceptance; same result with req_signed=1.
- Backpressure:
  - Hold resp_rdy=0 for 10 cycles after resp_val -> resp_prod stable, req_rdy=0, busy=1.
  - Toggle req_a/req_b during the wait -> no effect.
  - Raise resp_rdy -> retire, req_rdy=1 next cycle.
- Reset:
  - Assert reset 2 cycles into a 0xFF x 3 CALC -> next cycle IDLE, resp_val=0, resp_prod=0, req_rdy=1; no stale response appears.
  - A following 2 x 3 request gives 6.
- Re-run the directed set with A_W=4, B_W=12: 0xF x 0xFFF (unsigned) -> 0xE_FF1; -8 x -2048 -> 0x4000.
